// File: rtl/game_pkg.sv
// Shared game constants: tile codes, tile/sprite geometry, screen and map sizes.
// Also holds the mover's state encoding and a column clamp helper.
package game_pkg;

    typedef logic [7:0] tile_t;

    localparam tile_t TILE_BDR = 8'd0;
    localparam tile_t TILE_SKY = 8'd1;
    localparam tile_t TILE_BLK = 8'd2;
    localparam tile_t TILE_GND = 8'd3;

    localparam int BLOCK_WIDTH_PX     = 40;
    localparam int CHARACTER_WIDTH_PX = 42;
    localparam int SCREEN_HEIGHT_PX   = 480;
    localparam int MAX_FALL_SPEED_PX  = 4;
    localparam int GRAVITY_PERIOD_ST  = 4;
    localparam int OFFSCREEN_Y_PX     = 1000;

    localparam int MAP_ROWS = 12;
    localparam int MAP_COLS = 17;
    localparam int ROW_W    = $clog2(MAP_ROWS);
    localparam int COL_W    = $clog2(MAP_COLS);

    typedef logic [MAP_ROWS-1:0][MAP_COLS-1:0][7:0] tile_map_t;

    typedef enum logic [1:0] {
        ST_SPAWN    = 2'd0,
        ST_FALL     = 2'd1,
        ST_GROUNDED = 2'd2,
        ST_GONE     = 2'd3
    } gstate_e;

    function automatic logic [COL_W-1:0] clamp_col(input int c);
        if (c < 0) begin
            return '0;
        end else if (c > MAP_COLS - 1) begin
            return COL_W'(MAP_COLS - 1);
        end else begin
            return c[COL_W-1:0];
        end
    endfunction

endpackage

// File: rtl/goomba_gravity_mover_if.sv
// Signal bundle between the gravity mover and its surroundings.
// There is no handshake: every signal is a level, sampled once per movement step.
interface goomba_gravity_mover_if;
    import game_pkg::*;

    tile_map_t background;
    int        goomba_x;
    int        goomba_y_initial;
    logic      killed;
    int        goomba_y;
    logic      falling;
    logic      out_of_play;

    modport master (
        output background, goomba_x, goomba_y_initial, killed,
        input  goomba_y, falling, out_of_play
    );

    modport slave (
        input  background, goomba_x, goomba_y_initial, killed,
        output goomba_y, falling, out_of_play
    );
endinterface

// File: rtl/goomba_tile_probe.sv
// Combinational probe: is any of the sprite's three columns solid in the tile row
// holding pixel row y? Rows outside the map read as sky.
module goomba_tile_probe
    import game_pkg::*;
#(
    parameter tile_t BDR             = TILE_BDR,
    parameter tile_t SKY             = TILE_SKY,
    parameter tile_t BLK             = TILE_BLK,
    parameter tile_t GND             = TILE_GND,
    parameter int    CHARACTER_WIDTH = CHARACTER_WIDTH_PX,
    parameter int    BLOCK_WIDTH     = BLOCK_WIDTH_PX
) (
    input  int        x,
    input  int        y,
    input  tile_map_t background,
    output logic      solid
);

    int               row;
    logic [COL_W-1:0] cols [3];
    tile_t            tile;

    always_comb begin
        row     = y / BLOCK_WIDTH;
        cols[0] = clamp_col(x / BLOCK_WIDTH);
        cols[1] = clamp_col(x / BLOCK_WIDTH + 1);
        cols[2] = clamp_col((x + CHARACTER_WIDTH - 1) / BLOCK_WIDTH);
        tile    = SKY;
        solid   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tile = SKY;
            if (row >= 0 && row < MAP_ROWS) begin
                tile = background[row[ROW_W-1:0]][cols[i]];
            end
            // Border tiles stay passable even if a code map aliases them.
            if (tile != BDR && (tile == BLK || tile == GND)) begin
                solid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/goomba_gravity_mover.sv
// Vertical motion of a goomba: spawn, accelerating fall, landing on solid tiles,
// and retirement when it drops off screen or is stomped.
module goomba_gravity_mover
    import game_pkg::*;
#(
    parameter tile_t BDR             = TILE_BDR,
    parameter tile_t SKY             = TILE_SKY,
    parameter tile_t BLK             = TILE_BLK,
    parameter tile_t GND             = TILE_GND,
    parameter int    CHARACTER_WIDTH = CHARACTER_WIDTH_PX,
    parameter int    BLOCK_WIDTH     = BLOCK_WIDTH_PX,
    parameter int    SCREEN_HEIGHT   = SCREEN_HEIGHT_PX,
    parameter int    MAX_FALL_SPEED  = MAX_FALL_SPEED_PX,
    parameter int    GRAVITY_PERIOD  = GRAVITY_PERIOD_ST,
    parameter int    OFFSCREEN_Y     = OFFSCREEN_Y_PX
) (
    input  logic                    movement_clock,
    input  logic                    reset,
    goomba_gravity_mover_if.slave   bus,
    output gstate_e                 state_dbg
);

    gstate_e state_q, state_d;
    int      y_q, y_d;
    int      speed_q, speed_d;
    int      step_cnt_q, step_cnt_d;
    logic    falling_q;
    logic    out_of_play_q;

    int      ny;
    int      land_y;
    int      support_probe_y;
    int      landing_probe_y;
    logic    supported;
    logic    landing_solid;

    assign support_probe_y = y_q + CHARACTER_WIDTH;
    assign landing_probe_y = ny + CHARACTER_WIDTH - 1;

    goomba_tile_probe #(
        .BDR(BDR), .SKY(SKY), .BLK(BLK), .GND(GND),
        .CHARACTER_WIDTH(CHARACTER_WIDTH), .BLOCK_WIDTH(BLOCK_WIDTH)
    ) u_support_probe (
        .x          (bus.goomba_x),
        .y          (support_probe_y),
        .background (bus.background),
        .solid      (supported)
    );

    goomba_tile_probe #(
        .BDR(BDR), .SKY(SKY), .BLK(BLK), .GND(GND),
        .CHARACTER_WIDTH(CHARACTER_WIDTH), .BLOCK_WIDTH(BLOCK_WIDTH)
    ) u_landing_probe (
        .x          (bus.goomba_x),
        .y          (landing_probe_y),
        .background (bus.background),
        .solid      (landing_solid)
    );

    always_comb begin
        ny         = y_q + speed_q;
        land_y     = ((ny + CHARACTER_WIDTH - 1) / BLOCK_WIDTH) * BLOCK_WIDTH - CHARACTER_WIDTH;
        state_d    = state_q;
        y_d        = y_q;
        speed_d    = speed_q;
        step_cnt_d = step_cnt_q;

        case (state_q)
            ST_SPAWN: begin
                if (supported) begin
                    state_d = ST_GROUNDED;
                end else begin
                    state_d    = ST_FALL;
                    speed_d    = 1;
                    step_cnt_d = 0;
                end
            end
            ST_FALL: begin
                // Landing is checked first so it beats dropping off the screen.
                if (landing_solid) begin
                    state_d    = ST_GROUNDED;
                    y_d        = land_y;
                    speed_d    = 0;
                    step_cnt_d = 0;
                end else if (ny + CHARACTER_WIDTH >= SCREEN_HEIGHT) begin
                    state_d = ST_GONE;
                end else begin
                    y_d = ny;
                    if (step_cnt_q >= GRAVITY_PERIOD - 1) begin
                        step_cnt_d = 0;
                        if (speed_q < MAX_FALL_SPEED) begin
                            speed_d = speed_q + 1;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 1;
                    end
                end
            end
            ST_GROUNDED: begin
                if (!supported) begin
                    state_d    = ST_FALL;
                    speed_d    = 1;
                    step_cnt_d = 0;
                end
            end
            default: begin
                state_d = ST_GONE;
            end
        endcase

        if (bus.killed) begin
            state_d = ST_GONE;
        end
        if (state_d == ST_GONE) begin
            y_d = OFFSCREEN_Y;
        end
    end

    always_ff @(posedge movement_clock) begin
        if (reset) begin
            state_q       <= ST_SPAWN;
            y_q           <= bus.goomba_y_initial;
            speed_q       <= 0;
            step_cnt_q    <= 0;
            falling_q     <= 1'b0;
            out_of_play_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            y_q           <= y_d;
            speed_q       <= speed_d;
            step_cnt_q    <= step_cnt_d;
            falling_q     <= (state_d == ST_FALL);
            out_of_play_q <= (state_d == ST_GONE);
        end
    end

    assign bus.goomba_y    = y_q;
    assign bus.falling     = falling_q;
    assign bus.out_of_play = out_of_play_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_goomba_gravity_mover.sv
// Bench for goomba_gravity_mover: directed landing/fall-off/kill scenarios plus a
// randomized run, all scored against a step-level behavioural model.
module tb_goomba_gravity_mover;
    import game_pkg::*;

    localparam int W = 34;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    goomba_gravity_mover_if gif ();
    gstate_e dbg_state;

    goomba_gravity_mover dut (
        .movement_clock (clk),
        .reset          (rst),
        .bus            (gif),
        .state_dbg      (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    string phase = "init";

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d expected %0d at %0t", phase, tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_SPAWN = 0, M_FALL = 1, M_GROUND = 2, M_GONE = 3;
    int m_mode   = M_SPAWN;
    int m_y      = 0;
    int m_fsteps = 0;

    function automatic bit solid_at(input int x, input int ypix);
        int row;
        int c [3];
        tile_t t;
        row = ypix / BLOCK_WIDTH_PX;
        if (row < 0 || row > MAP_ROWS - 1) return 1'b0;
        c[0] = x / BLOCK_WIDTH_PX;
        c[1] = x / BLOCK_WIDTH_PX + 1;
        c[2] = (x + CHARACTER_WIDTH_PX - 1) / BLOCK_WIDTH_PX;
        for (int i = 0; i < 3; i++) begin
            if (c[i] < 0) c[i] = 0;
            if (c[i] > MAP_COLS - 1) c[i] = MAP_COLS - 1;
            t = gif.background[row][c[i]];
            if (t == TILE_BLK || t == TILE_GND) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        int spd;
        int ny;
        if (rst) begin
            m_mode   = M_SPAWN;
            m_y      = gif.goomba_y_initial;
            m_fsteps = 0;
        end else if (gif.killed) begin
            m_mode = M_GONE;
            m_y    = OFFSCREEN_Y_PX;
        end else begin
            case (m_mode)
                M_SPAWN: begin
                    if (solid_at(gif.goomba_x, m_y + CHARACTER_WIDTH_PX)) m_mode = M_GROUND;
                    else begin
                        m_mode   = M_FALL;
                        m_fsteps = 0;
                    end
                end
                M_FALL: begin
                    spd = 1 + m_fsteps / GRAVITY_PERIOD_ST;
                    if (spd > MAX_FALL_SPEED_PX) spd = MAX_FALL_SPEED_PX;
                    ny = m_y + spd;
                    if (solid_at(gif.goomba_x, ny + CHARACTER_WIDTH_PX - 1)) begin
                        m_y    = ((ny + CHARACTER_WIDTH_PX - 1) / BLOCK_WIDTH_PX) * BLOCK_WIDTH_PX
                                 - CHARACTER_WIDTH_PX;
                        m_mode = M_GROUND;
                    end else if (ny + CHARACTER_WIDTH_PX >= SCREEN_HEIGHT_PX) begin
                        m_mode = M_GONE;
                        m_y    = OFFSCREEN_Y_PX;
                    end else begin
                        m_y = ny;
                        m_fsteps++;
                    end
                end
                M_GROUND: begin
                    if (!solid_at(gif.goomba_x, m_y + CHARACTER_WIDTH_PX)) begin
                        m_mode   = M_FALL;
                        m_fsteps = 0;
                    end
                end
                default: m_y = OFFSCREEN_Y_PX;
            endcase
        end
        exp_q.push_back({m_y[31:0], (m_mode == M_FALL), (m_mode == M_GONE)});
    endtask

    // ---------------- driver tasks ----------------
    task automatic step_cycle();
        logic [W-1:0] e;
        model_step();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("y", gif.goomba_y, e[33:2]);
        check_eq("falling", 32'(gif.falling), 32'(e[1]));
        check_eq("out_of_play", 32'(gif.out_of_play), 32'(e[0]));
    endtask

    task automatic clear_map();
        for (int r = 0; r < MAP_ROWS; r++)
            for (int c = 0; c < MAP_COLS; c++)
                gif.background[r][c] = TILE_SKY;
    endtask

    task automatic ground_row11();
        clear_map();
        for (int c = 0; c < MAP_COLS; c++) gif.background[11][c] = TILE_GND;
    endtask

    task automatic random_map();
        int v;
        for (int r = 0; r < MAP_ROWS; r++)
            for (int c = 0; c < MAP_COLS; c++) begin
                v = $urandom_range(0, 11);
                if (r == 11 && v > 3) gif.background[r][c] = TILE_GND;
                else if (v < 7) gif.background[r][c] = TILE_SKY;
                else if (v < 8) gif.background[r][c] = TILE_BDR;
                else if (v < 10) gif.background[r][c] = TILE_BLK;
                else gif.background[r][c] = TILE_GND;
            end
    endtask

    task automatic do_reset(input int y_init);
        gif.goomba_y_initial = y_init;
        rst = 1'b1;
        step_cycle();
        rst = 1'b0;
    endtask

    task automatic fall_until_stop(input int budget);
        int k;
        k = 0;
        while (gif.falling && k < budget) begin
            step_cycle();
            k++;
        end
        check_eq("fall_bound", 32'(gif.falling), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        gif.killed           = 1'b0;
        gif.goomba_x         = 100;
        gif.goomba_y_initial = 0;
        ground_row11();

        // Drop from the top onto row-11 ground, watching the speed ramp.
        phase = "ramp";
        do_reset(0);
        check_eq("rst_y", gif.goomba_y, 32'd0);
        check_eq("rst_falling", 32'(gif.falling), 32'd0);
        check_eq("rst_oop", 32'(gif.out_of_play), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(ST_SPAWN));
        step_cycle();
        check_eq("spawn_to_fall", 32'(gif.falling), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            step_cycle();
            if (i == 4)  check_eq("y_after_4", gif.goomba_y, 32'd4);
            if (i == 8)  check_eq("y_after_8", gif.goomba_y, 32'd12);
            if (i == 12) check_eq("y_after_12", gif.goomba_y, 32'd24);
            if (i == 16) check_eq("y_after_16", gif.goomba_y, 32'd40);
        end
        fall_until_stop(300);
        check_eq("landed_y", gif.goomba_y, 32'd398);

        // Spawn already standing on ground.
        phase = "spawn_grounded";
        do_reset(398);
        step_cycle();
        check_eq("grounded_state", 32'(dbg_state), 32'(ST_GROUNDED));
        for (int i = 0; i < 100; i++) step_cycle();
        check_eq("held_y", gif.goomba_y, 32'd398);

        // Ground removed under it: fall off the bottom of the screen.
        phase = "fall_off";
        for (int c = 2; c <= 4; c++) gif.background[11][c] = TILE_SKY;
        step_cycle();
        check_eq("walkoff_falling", 32'(gif.falling), 32'd1);
        check_eq("walkoff_no_move", gif.goomba_y, 32'd398);
        step_cycle();
        step_cycle();
        check_eq("y_increasing", 32'(gif.goomba_y > 398), 32'd1);
        fall_until_stop(100);
        check_eq("gone_y", gif.goomba_y, 32'd1000);
        check_eq("gone_oop", 32'(gif.out_of_play), 32'd1);
        for (int i = 0; i < 5; i++) step_cycle();
        check_eq("gone_absorbing", gif.goomba_y, 32'd1000);

        // Land on a single block seen only by the middle column.
        phase = "middle_col";
        clear_map();
        gif.background[5][3] = TILE_BLK;
        gif.goomba_x = 119;
        do_reset(0);
        step_cycle();
        fall_until_stop(300);
        check_eq("mid_land_y", gif.goomba_y, 32'd158);

        // Stomped mid-fall, then reset brings it back.
        phase = "killed";
        ground_row11();
        gif.goomba_x = 100;
        do_reset(0);
        begin
            int k;
            k = 0;
            while (gif.goomba_y < 200 && k < 300) begin
                step_cycle();
                k++;
            end
        end
        check_eq("reach_200", gif.goomba_y, 32'd200);
        gif.killed = 1'b1;
        step_cycle();
        gif.killed = 1'b0;
        check_eq("killed_y", gif.goomba_y, 32'd1000);
        check_eq("killed_oop", 32'(gif.out_of_play), 32'd1);
        gif.killed = 1'b1;
        do_reset(37);
        gif.killed = 1'b0;
        check_eq("rearm_y", gif.goomba_y, 32'd37);
        check_eq("rearm_oop", 32'(gif.out_of_play), 32'd0);

        // Randomized maps, positions, kills and resets.
        phase = "random";
        random_map();
        do_reset($urandom_range(0, 430));
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (rst) begin
                random_map();
                gif.goomba_y_initial = $urandom_range(0, 430);
            end
            gif.killed = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 7) == 0) gif.goomba_x = $urandom_range(0, 700);
            else begin
                gif.goomba_x = gif.goomba_x + int'($urandom_range(0, 4)) - 2;
                if (gif.goomba_x < 0) gif.goomba_x = 0;
            end
            step_cycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
